mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory-access / write-back stage directly downstream of the 16-bit ALU execute register.
- Consumes the registered ALU result, the store data, the decoded opcode and the destination index. Performs LD/ST transactions on an external data-memory port with a req/ack handshake and drives the register-file write-back port.
- Stalls the upstream pipeline while a memory transaction is pending or after HLT.

Parameters:
- TIMEOUT, 16, maximum cycles spent in REQ without dm_ack before the access is aborted (range 2..255).
- RD_W, 3, width of the destination register index.

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- valid_ex  input  1  execute register holds a valid instruction
- op_ex  input  6  opcode registered alongside ans_ex
- ans_ex  input  16  ALU result; the address for LD/ST
- DM_data  input  16  store data (registered B operand)
- rd_ex  input  RD_W  destination register index
- dm_rdata  input  16  data-memory read data, valid in the cycle dm_ack=1
- dm_ack  input  1  data-memory completion strobe
- dm_req  output  1  memory request
- dm_we  output  1  1 = write (ST), 0 = read (LD)
- dm_addr  output  16  memory address
- dm_wdata  output  16  memory write data
- wb_en  output  1  register-file write enable, one-cycle pulse
- wb_rd  output  RD_W  write-back register index
- wb_data  output  16  write-back value
- stall  output  1  upstream must hold execute register contents
- halted  output  1  HLT retired
- mem_err  output  1  sticky: an access timed out

Behaviour:
- Reset (async, active-high): all outputs 0, state = IDLE, timeout counter = 0, mem_err = 0.
- States: IDLE, REQ, HALT.
- stall = (state != IDLE), combinational from the state register only.
- Capture happens at a posedge when state = IDLE and valid_ex = 1.
- Write-back opcodes are 000000–001010, 001100–001111, 010110, 011001–011011.
  - At capture: wb_en = 1, wb_rd = rd_ex, wb_data = ans_ex, registered, so visible the next cycle.
  - Latency is 1 cycle. State stays IDLE, so back-to-back instructions are accepted every cycle.
- No-effect opcodes are 010000, 010111, 011000, 011100–011111, 001011 and all undefined codes. They produce wb_en = 0 with no state change.
- LD (010100) / ST (010101) at capture:
  - Next state = REQ.
  - Latch dm_addr = ans_ex, dm_wdata = DM_data, dm_we = (op = ST), wb_rd = rd_ex.
  - Set dm_req = 1 and clear the counter.
- REQ state:
  - dm_req, dm_addr, dm_we and dm_wdata are held stable.
  - Each posedge without dm_ack increments the counter.
  - Posedge with dm_ack = 1: dm_req drops to 0 and next state = IDLE.
    - LD: wb_en = 1 and wb_data = dm_rdata for one cycle.
    - ST: no write-back.
    - Total LD latency = 1 + ack wait cycles + 1.
  - Timeout: at the posedge where the counter = TIMEOUT−1 and dm_ack = 0, the access is aborted.
    - dm_req drops, mem_err is set, no write-back, next state = IDLE.
  - dm_ack outside REQ is ignored.
- dm_ack in the same cycle as the timeout edge: the ack wins and the access completes normally.
- HLT (010001) at capture: next state = HALT, halted = 1, stall = 1. HALT is left only by reset.
- wb_en is deasserted in every cycle that does not have a write-back event defined above.
- Reset mid-REQ: dm_req drops immediately (asynchronously), with no write-back. mem_err is cleared only by reset.
- All address and data paths are 16-bit and pass through unmodified; there is no arithmetic in this stage other than the counter.

Test Plan:
- Single ADD write-back: valid_ex=1, op=000000, ans_ex=16'h1234, rd=3 for one cycle → next cycle wb_en=1, wb_rd=3, wb_data=16'h1234. The following cycle wb_en=0 and stall stays 0 throughout.
- LD with 2-cycle ack delay: op=010100, ans_ex=16'h0040. Memory acks on the 3rd REQ cycle with dm_rdata=16'hBEEF.
  - dm_req=1 and dm_addr=16'h0040 for 3 cycles; stall=1 for the same window.
  - wb_en=1 with wb_data=16'hBEEF on the cycle after the ack; stall=0 after that.
- ST, then an ADD held by stall:
  - ST with ans_ex=16'h0010, DM_data=16'h00AA; ack after 1 cycle → dm_we=1, dm_wdata=16'h00AA, no wb_en.
  - The held ADD (ans_ex=5) is captured the cycle after stall falls → wb_data=5.
- Timeout with TIMEOUT=4: LD, dm_ack tied 0 → dm_req high exactly 4 cycles, then 0. mem_err=1 and stays 1, no wb_en, stall=0 afterwards.
- Ack and timeout on the same edge: TIMEOUT=4, ack on the 4th REQ cycle → normal LD completion and mem_err=0.
- HLT: op=010001 → halted=1 and stall=1 indefinitely. Reset asserted asynchronously mid-cycle → all outputs 0 immediately, and state is IDLE after release.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: performs LD/ST over a req/ack data-memory
// port with a timeout, drives the register-file write-back port, and stalls upstream.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned RD_W    = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_ex,
    input  logic [5:0]      op_ex,
    input  logic [15:0]     ans_ex,
    input  logic [15:0]     DM_data,
    input  logic [RD_W-1:0] rd_ex,
    input  logic [15:0]     dm_rdata,
    input  logic            dm_ack,
    output logic            dm_req,
    output logic            dm_we,
    output logic [15:0]     dm_addr,
    output logic [15:0]     dm_wdata,
    output logic            wb_en,
    output logic [RD_W-1:0] wb_rd,
    output logic [15:0]     wb_data,
    output logic            stall,
    output logic            halted,
    output logic            mem_err
);

    localparam int unsigned DW  = 16;
    localparam int unsigned OPW = 6;
    localparam int unsigned CW  = 8;

    localparam logic [OPW-1:0] OP_LD  = 6'b010100;
    localparam logic [OPW-1:0] OP_ST  = 6'b010101;
    localparam logic [OPW-1:0] OP_HLT = 6'b010001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dm_req_q, dm_req_d;
    logic            dm_we_q, dm_we_d;
    logic [DW-1:0]   dm_addr_q, dm_addr_d;
    logic [DW-1:0]   dm_wdata_q, dm_wdata_d;
    logic            wb_en_q, wb_en_d;
    logic [RD_W-1:0] wb_rd_q, wb_rd_d;
    logic [DW-1:0]   wb_data_q, wb_data_d;
    logic            halted_q, halted_d;
    logic            mem_err_q, mem_err_d;

    // Opcodes that retire with a register-file write of the ALU result
    function automatic logic is_wb_op(input logic [OPW-1:0] op);
        return op inside {[6'd0:6'd10], [6'd12:6'd15], 6'd22, [6'd25:6'd27]};
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        wb_en_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        halted_d   = halted_q;
        mem_err_d  = mem_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (valid_ex) begin
                    if (op_ex == OP_LD || op_ex == OP_ST) begin
                        state_d    = S_REQ;
                        cnt_d      = '0;
                        dm_req_d   = 1'b1;
                        dm_we_d    = (op_ex == OP_ST);
                        dm_addr_d  = ans_ex;
                        dm_wdata_d = DM_data;
                        wb_rd_d    = rd_ex;
                    end else if (op_ex == OP_HLT) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else if (is_wb_op(op_ex)) begin
                        wb_en_d   = 1'b1;
                        wb_rd_d   = rd_ex;
                        wb_data_d = ans_ex;
                    end
                end
            end
            S_REQ: begin
                // An ack on the timeout edge still completes the access
                if (dm_ack) begin
                    state_d  = S_IDLE;
                    dm_req_d = 1'b0;
                    if (!dm_we_q) begin
                        wb_en_d   = 1'b1;
                        wb_data_d = dm_rdata;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = S_IDLE;
                    dm_req_d  = 1'b0;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HALT: begin
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            wb_en_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            halted_q   <= 1'b0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            wb_en_q    <= wb_en_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            halted_q   <= halted_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign dm_req   = dm_req_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_wdata = dm_wdata_q;
    assign wb_en    = wb_en_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign halted   = halted_q;
    assign mem_err  = mem_err_q;
    assign stall    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus random traffic, all checked
// against a transaction-level model of the stage.
module tb_mem_wb_stage;

    localparam int unsigned RD_W = 3;
    localparam int unsigned TO   = 4;
    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_LD  = 6'b010100;
    localparam logic [5:0] OP_ST  = 6'b010101;
    localparam logic [5:0] OP_HLT = 6'b010001;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            valid_ex = 1'b0;
    logic [5:0]      op_ex = '0;
    logic [15:0]     ans_ex = '0;
    logic [15:0]     DM_data = '0;
    logic [RD_W-1:0] rd_ex = '0;
    logic [15:0]     dm_rdata = '0;
    logic            dm_ack = 1'b0;
    logic            dm_req, dm_we, wb_en, stall, halted, mem_err;
    logic [15:0]     dm_addr, dm_wdata, wb_data;
    logic [RD_W-1:0] wb_rd;

    int total = 0;
    int bad = 0;

    mem_wb_stage #(.TIMEOUT(TO), .RD_W(RD_W)) dut (
        .clk(clk), .reset(reset), .valid_ex(valid_ex), .op_ex(op_ex),
        .ans_ex(ans_ex), .DM_data(DM_data), .rd_ex(rd_ex),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .stall(stall), .halted(halted), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Model: mode 0 = accepting, 1 = memory access in flight, 2 = halted
    int              m_mode = 0;
    int              m_waited = 0;
    logic [63:0]     wb_mask = 64'h0000_0000_0E40_F7FF;
    logic            e_req = 0, e_we = 0, e_wb = 0, e_halt = 0, e_err = 0;
    logic [15:0]     e_addr = '0, e_wdata = '0, e_wbdata = '0;
    logic [RD_W-1:0] e_wbrd = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_waited = 0;
        e_req = 0; e_we = 0; e_wb = 0; e_halt = 0; e_err = 0;
        e_addr = '0; e_wdata = '0; e_wbdata = '0; e_wbrd = '0;
    endtask

    task automatic model_step();
        e_wb = 0;
        if (m_mode == 0 && valid_ex) begin
            if (op_ex == OP_LD || op_ex == OP_ST) begin
                m_mode = 1; m_waited = 0;
                e_req = 1; e_we = (op_ex == OP_ST);
                e_addr = ans_ex; e_wdata = DM_data; e_wbrd = rd_ex;
            end else if (op_ex == OP_HLT) begin
                m_mode = 2; e_halt = 1;
            end else if (wb_mask[op_ex]) begin
                e_wb = 1; e_wbrd = rd_ex; e_wbdata = ans_ex;
            end
        end else if (m_mode == 1) begin
            m_waited++;
            if (dm_ack) begin
                m_mode = 0; e_req = 0;
                if (!e_we) begin e_wb = 1; e_wbdata = dm_rdata; end
            end else if (m_waited == TO) begin
                m_mode = 0; e_req = 0; e_err = 1;
            end
        end
    endtask

    task automatic check_all();
        check("dm_req", 32'(dm_req), 32'(e_req));
        check("wb_en", 32'(wb_en), 32'(e_wb));
        check("stall", 32'(stall), 32'(m_mode != 0));
        check("halted", 32'(halted), 32'(e_halt));
        check("mem_err", 32'(mem_err), 32'(e_err));
        if (e_req) begin
            check("dm_addr", 32'(dm_addr), 32'(e_addr));
            check("dm_we", 32'(dm_we), 32'(e_we));
            check("dm_wdata", 32'(dm_wdata), 32'(e_wdata));
        end
        if (e_wb) begin
            check("wb_rd", 32'(wb_rd), 32'(e_wbrd));
            check("wb_data", 32'(wb_data), 32'(e_wbdata));
        end
    endtask

    // One clock: drive on negedge, model the posedge, sample just after it
    task automatic cyc(input logic v, input logic [5:0] op, input logic [15:0] ans,
                       input logic [15:0] dmd, input logic [RD_W-1:0] rd,
                       input logic ack, input logic [15:0] rdata);
        @(negedge clk);
        valid_ex = v; op_ex = op; ans_ex = ans; DM_data = dmd; rd_ex = rd;
        dm_ack = ack; dm_rdata = rdata;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle(input logic ack, input logic [15:0] rdata);
        cyc(1'b0, OP_ADD, 16'h0, 16'h0, '0, ack, rdata);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        valid_ex = 1'b0;
        #1;
        check("rst_dm_req", 32'(dm_req), 32'h0);
        check("rst_wb_en", 32'(wb_en), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_mem_err", 32'(mem_err), 32'h0);
        check("rst_dm_addr", 32'(dm_addr), 32'h0);
        check("rst_wb_data", 32'(wb_data), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        logic [5:0] op;
        int r;

        model_reset();
        do_reset();

        // ADD write-back with one-cycle latency
        cyc(1'b1, OP_ADD, 16'h1234, 16'h0, 3'd3, 1'b0, 16'h0);
        check("add_wb_en", 32'(wb_en), 32'h1);
        check("add_wb_rd", 32'(wb_rd), 32'h3);
        check("add_wb_data", 32'(wb_data), 32'h1234);
        check("add_stall", 32'(stall), 32'h0);
        idle(1'b0, 16'h0);
        check("add_wb_off", 32'(wb_en), 32'h0);

        // LD acked on the third REQ cycle
        cyc(1'b1, OP_LD, 16'h0040, 16'h0, 3'd5, 1'b0, 16'h0);
        check("ld_req", 32'(dm_req), 32'h1);
        check("ld_addr", 32'(dm_addr), 32'h0040);
        idle(1'b0, 16'h0);
        idle(1'b0, 16'h0);
        check("ld_stall", 32'(stall), 32'h1);
        idle(1'b1, 16'hBEEF);
        check("ld_wb_en", 32'(wb_en), 32'h1);
        check("ld_wb_data", 32'(wb_data), 32'hBEEF);
        check("ld_stall_off", 32'(stall), 32'h0);

        // ST, then an ADD held upstream until the stall drops
        cyc(1'b1, OP_ST, 16'h0010, 16'h00AA, 3'd1, 1'b0, 16'h0);
        check("st_we", 32'(dm_we), 32'h1);
        check("st_wdata", 32'(dm_wdata), 32'h00AA);
        cyc(1'b1, OP_ADD, 16'd5, 16'h0, 3'd2, 1'b1, 16'hFFFF);
        check("st_no_wb", 32'(wb_en), 32'h0);
        cyc(1'b1, OP_ADD, 16'd5, 16'h0, 3'd2, 1'b0, 16'h0);
        check("held_add", 32'(wb_data), 32'd5);

        // Timeout with no ack: dm_req high exactly TIMEOUT cycles
        cyc(1'b1, OP_LD, 16'h0100, 16'h0, 3'd4, 1'b0, 16'h0);
        n = 1;
        for (int i = 0; i < 10 && dm_req; i++) begin
            idle(1'b0, 16'h0);
            if (dm_req) n++;
        end
        check("to_req_cycles", 32'(n), 32'(TO));
        check("to_err", 32'(mem_err), 32'h1);
        idle(1'b0, 16'h0);
        check("to_err_sticky", 32'(mem_err), 32'h1);

        // Ack on the timeout edge completes normally
        do_reset();
        cyc(1'b1, OP_LD, 16'h0200, 16'h0, 3'd6, 1'b0, 16'h0);
        for (int i = 0; i < int'(TO) - 1; i++) idle(1'b0, 16'h0);
        idle(1'b1, 16'h5A5A);
        check("race_wb", 32'(wb_en), 32'h1);
        check("race_data", 32'(wb_data), 32'h5A5A);
        check("race_err", 32'(mem_err), 32'h0);

        // HLT holds forever until reset
        cyc(1'b1, OP_HLT, 16'h0, 16'h0, '0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) cyc(1'b1, OP_ADD, 16'h7, 16'h0, 3'd1, 1'b1, 16'h1);
        check("hlt_halted", 32'(halted), 32'h1);
        check("hlt_stall", 32'(stall), 32'h1);
        do_reset();

        // Random traffic with random memory latency and occasional resets
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 15) op = OP_LD;
            else if (r < 30) op = OP_ST;
            else if (r < 31) op = OP_HLT;
            else op = 6'($urandom_range(0, 63));
            cyc(1'($urandom_range(0, 3) != 0), op, 16'($urandom), 16'($urandom),
                RD_W'($urandom), 1'($urandom_range(0, 9) < 3), 16'($urandom));
            if (m_mode == 2 && $urandom_range(0, 3) == 0) do_reset();
            else if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
